// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue unit: drives register file read addresses, tracks pending
// writebacks in a per-register scoreboard, stalls on RAW/WAW and fills ID/EX.
module id_issue_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [ADDR_W-1:0]      src1,
  input  logic [ADDR_W-1:0]      src2,
  input  logic                   use_src1,
  input  logic                   use_src2,
  input  logic [ADDR_W-1:0]      dest,
  input  logic                   wb_req,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      rf_src1,
  output logic [ADDR_W-1:0]      rf_src2,
  input  logic [DATA_W-1:0]      rf_reg1,
  input  logic [DATA_W-1:0]      rf_reg2,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_dest,
  output logic                   stall,
  output logic                   ex_valid,
  output logic                   ex_wb_en,
  output logic [ADDR_W-1:0]      ex_dest,
  output logic [DATA_W-1:0]      ex_val1,
  output logic [DATA_W-1:0]      ex_val2,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] eb;
  logic [NREG-1:0] busy_next;
  logic            raw;
  logic            waw;
  logic            hazard;
  logic            issue;
  logic            dest_wr;

  assign rf_src1 = src1;
  assign rf_src2 = src2;

  // A retiring writeback frees its register in the same cycle, since the
  // register file writes on the falling edge and the operand is already new.
  always_comb begin
    clr = '0;
    if (wb_en && (wb_dest != '0)) clr[wb_dest] = 1'b1;
  end

  assign eb      = busy & ~clr;
  assign dest_wr = wb_req & (dest != '0);

  assign raw    = (use_src1 & (src1 != '0) & eb[src1]) |
                  (use_src2 & (src2 != '0) & eb[src2]);
  assign waw    = dest_wr & eb[dest];
  assign hazard = raw | waw;

  assign stall = instr_valid & ~flush & hazard;
  assign issue = instr_valid & ~flush & ~hazard;

  always_comb begin
    set = '0;
    if (issue && dest_wr) set[dest] = 1'b1;
  end

  // OR-ing set after the clear lets a same-cycle set win over a retiring write.
  assign busy_next = eb | set;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      ex_valid <= 1'b0;
      ex_wb_en <= 1'b0;
      ex_dest  <= '0;
      ex_val1  <= '0;
      ex_val2  <= '0;
    end else begin
      busy     <= busy_next;
      ex_valid <= issue;
      ex_wb_en <= issue & dest_wr;
      if (issue) begin
        ex_dest <= dest;
        ex_val1 <= rf_reg1;
        ex_val2 <= rf_reg2;
      end
    end
  end

endmodule
